fpu_cvt_to_int_pipe: RTL and testbench

FPU_CVT_TO_INT_PIPE -- requirements
Module: fpu_cvt_to_int_pipe

---
 rtl/fpu_cvt_to_int_pipe.sv | 183 ++++++++++++++++++
 tb/tb_fpu_cvt_to_int_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_cvt_to_int_pipe.sv
// Float-to-integer conversion, two-stage pipeline with valid/ready handshake.
// Stage 1 classifies the operand and aligns its significand into an integer
// magnitude plus guard/round/sticky bits; stage 2 rounds, range-checks,
// saturates and applies the sign.
module fpu_cvt_to_int_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int INT_W = 32
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   flush_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [EXP_W+MAN_W:0]   op_a_i,
   input  logic                   is_unsigned_i,
   input  logic [2:0]             rounding_mode_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [INT_W-1:0]       result_o,
   output logic                   flag_nv_o,
   output logic                   flag_nx_o
);

   localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
   localparam int SIG_W = MAN_W + 1;
   // Alignment window: INT_W integer bits on top, then G, R and sticky source.
   localparam int AW    = SIG_W + INT_W + 1;
   localparam int FB    = MAN_W + 2;
   localparam int SHW   = $clog2(INT_W + 2) + 1;

   // Increment decision; modes 001 and the reserved 101..111 truncate.
   function automatic logic round_up(input logic [2:0] rm, input logic neg,
                                     input logic lsb, input logic g,
                                     input logic r, input logic s);
      logic inc;
      case (rm)
         3'b000:  inc = g & (r | s | lsb);
         3'b010:  inc = neg & (g | r | s);
         3'b011:  inc = !neg & (g | r | s);
         3'b100:  inc = g;
         default: inc = 1'b0;
      endcase
      return inc;
   endfunction

   // Clamp value for an out-of-range result of the given sign and target.
   function automatic logic [INT_W-1:0] sat_value(input logic neg, input logic uns);
      logic [INT_W-1:0] v;
      if (uns) v = neg ? '0 : '1;
      else     v = neg ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
      return v;
   endfunction

   logic                   adv_p1, adv_p2;
   logic                   sign_in;
   logic [EXP_W-1:0]       exp_in;
   logic [MAN_W-1:0]       frac_in;
   logic [SIG_W-1:0]       sig_in;
   int                     exp_unb;
   logic [SHW-1:0]         sh_amt;
   logic [AW-1:0]          aligned;

   logic                   nan_p1_d, big_p1_d, g_p1_d, r_p1_d, s_p1_d;
   logic [INT_W-1:0]       mag_p1_d;

   logic                   vld_p1_q, sign_p1_q, uns_p1_q, nan_p1_q, big_p1_q;
   logic                   g_p1_q, r_p1_q, s_p1_q;
   logic [2:0]             rm_p1_q;
   logic [INT_W-1:0]       mag_p1_q;

   logic                   rnd_inc, fits;
   logic [INT_W:0]         rnd_mag;
   logic [INT_W-1:0]       result_d;
   logic                   nv_d, nx_d;

   logic                   vld_p2_q;
   logic [INT_W-1:0]       result_q;
   logic                   nv_q, nx_q;

   assign adv_p2      = !vld_p2_q | out_ready_i;
   assign adv_p1      = !vld_p1_q | adv_p2;
   assign in_ready_o  = adv_p1;
   assign out_valid_o = vld_p2_q;
   assign result_o    = result_q;
   assign flag_nv_o   = nv_q;
   assign flag_nx_o   = nx_q;

   assign sign_in = op_a_i[EXP_W+MAN_W];
   assign exp_in  = op_a_i[EXP_W+MAN_W-1:MAN_W];
   assign frac_in = op_a_i[MAN_W-1:0];
   assign sig_in  = {|exp_in, frac_in};

   // Classify and align: tiny values collapse to sticky, huge ones to overflow.
   always_comb begin
      exp_unb  = (exp_in == '0) ? (1 - BIAS) : (int'(exp_in) - BIAS);
      nan_p1_d = (&exp_in) & (|frac_in);
      big_p1_d = (&exp_in) | (exp_unb > INT_W - 1);
      sh_amt   = '0;
      aligned  = '0;
      mag_p1_d = '0;
      g_p1_d   = 1'b0;
      r_p1_d   = 1'b0;
      s_p1_d   = 1'b0;
      if (exp_unb < -2) begin
         s_p1_d = |sig_in;
      end else if (exp_unb <= INT_W - 1) begin
         sh_amt   = SHW'(exp_unb + 2);
         aligned  = {{(INT_W+1){1'b0}}, sig_in} << sh_amt;
         mag_p1_d = aligned[AW-1:FB];
         g_p1_d   = aligned[FB-1];
         r_p1_d   = aligned[FB-2];
         s_p1_d   = |aligned[FB-3:0];
      end
   end

   // ---- stage 1 boundary: aligned magnitude + G/R/S ----
   // Stage 1 valid bit.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i)     vld_p1_q <= 1'b0;
      else if (flush_i) vld_p1_q <= 1'b0;
      else if (adv_p1)  vld_p1_q <= in_valid_i;
   end

   // Stage 1 payload, captured on accept.
   always_ff @(posedge clk_i) begin
      if (adv_p1 && in_valid_i) begin
         sign_p1_q <= sign_in;
         uns_p1_q  <= is_unsigned_i;
         rm_p1_q   <= rounding_mode_i;
         nan_p1_q  <= nan_p1_d;
         big_p1_q  <= big_p1_d;
         mag_p1_q  <= mag_p1_d;
         g_p1_q    <= g_p1_d;
         r_p1_q    <= r_p1_d;
         s_p1_q    <= s_p1_d;
      end
   end

   // Round, range-check on the rounded magnitude, then saturate or sign.
   always_comb begin
      rnd_inc  = round_up(rm_p1_q, sign_p1_q, mag_p1_q[0], g_p1_q, r_p1_q, s_p1_q);
      rnd_mag  = {1'b0, mag_p1_q} + {{INT_W{1'b0}}, rnd_inc};
      fits     = 1'b0;
      result_d = '0;
      nv_d     = 1'b0;
      nx_d     = 1'b0;
      if (uns_p1_q)       fits = sign_p1_q ? (rnd_mag == '0) : !rnd_mag[INT_W];
      else if (sign_p1_q) fits = !rnd_mag[INT_W] &&
                                 (!rnd_mag[INT_W-1] || (rnd_mag[INT_W-2:0] == '0));
      else                fits = (rnd_mag[INT_W:INT_W-1] == 2'b00);
      if (nan_p1_q) begin
         result_d = sat_value(1'b0, uns_p1_q);
         nv_d     = 1'b1;
      end else if (big_p1_q || !fits) begin
         result_d = sat_value(sign_p1_q, uns_p1_q);
         nv_d     = 1'b1;
      end else begin
         result_d = sign_p1_q ? ('0 - rnd_mag[INT_W-1:0]) : rnd_mag[INT_W-1:0];
         nx_d     = g_p1_q | r_p1_q | s_p1_q;
      end
   end

   // ---- stage 2 boundary: final result and flags ----
   // Stage 2 valid and output registers; payload holds while stalled.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         vld_p2_q <= 1'b0;
         result_q <= '0;
         nv_q     <= 1'b0;
         nx_q     <= 1'b0;
      end else begin
         if (flush_i)     vld_p2_q <= 1'b0;
         else if (adv_p2) vld_p2_q <= vld_p1_q;
         if (adv_p2 && vld_p1_q) begin
            result_q <= result_d;
            nv_q     <= nv_d;
            nx_q     <= nx_d;
         end
      end
   end

endmodule

// File: tb/tb_fpu_cvt_to_int_pipe.sv
// Bench for fpu_cvt_to_int_pipe (binary32 -> int32): directed literals,
// backpressure, flush, reset and randomized traffic against a rational model.
module tb_fpu_cvt_to_int_pipe;

   logic        clk_i = 1'b0;
   logic        reset_i, flush_i, in_valid_i, in_ready_o, is_unsigned_i;
   logic        out_valid_o, out_ready_i, flag_nv_o, flag_nx_o;
   logic [31:0] op_a_i, result_o;
   logic [2:0]  rounding_mode_i;

   typedef struct packed { logic [31:0] res; logic nv; logic nx; } res_t;
   typedef struct {
      logic [31:0] op; logic uns; logic [2:0] rm;
      res_t exp; bit has_lit; res_t lit;
   } ent_t;

   ent_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   bit   chk_empty_next = 0;
   bit   rand_rdy = 0;
   bit   lit_en = 0;
   res_t lit_val = '0;
   bit   rdy_chk_en = 0;
   bit   rdy_chk_val = 0;

   always #5 clk_i = ~clk_i;

   fpu_cvt_to_int_pipe #(.EXP_W(8), .MAN_W(23), .INT_W(32)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .op_a_i(op_a_i),
      .is_unsigned_i(is_unsigned_i), .rounding_mode_i(rounding_mode_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
      .flag_nv_o(flag_nv_o), .flag_nx_o(flag_nx_o));

   function automatic res_t sat(input logic sgn, input logic uns);
      res_t o;
      o.nv = 1'b1; o.nx = 1'b0;
      if (uns) o.res = sgn ? 32'h0 : 32'hFFFF_FFFF;
      else     o.res = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return o;
   endfunction

   // Exact value = sig * 2^(e-23); split into quotient and remainder vs one half.
   function automatic res_t model(input logic [31:0] op, input logic uns, input logic [2:0] rm);
      res_t o;
      logic sgn;
      int ex, e, k;
      longint unsigned sig, q, rem, half, n;
      bit inexact, gt, eq, up, in_rng;
      longint v;
      o = '0;
      sgn = op[31];
      ex = int'(op[30:23]);
      if (ex == 255 && op[22:0] != 0) begin
         o.res = uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
         o.nv = 1'b1;
         return o;
      end
      if (ex == 255) return sat(sgn, uns);
      sig = longint'(op[22:0]) + ((ex != 0) ? (64'd1 << 23) : 64'd0);
      e = (ex == 0) ? -126 : ex - 127;
      if (e >= 40) return sat(sgn, uns);
      k = 23 - e;
      rem = 0;
      if (k <= 0) begin
         q = sig << (-k); gt = 0; eq = 0; inexact = 0;
      end else if (k >= 40) begin
         q = 0; gt = 0; eq = 0; inexact = (sig != 0);
      end else begin
         q = sig >> k;
         rem = sig - (q << k);
         half = 64'd1 << (k - 1);
         gt = rem > half; eq = rem == half; inexact = rem != 0;
      end
      case (rm)
         3'd0:    up = gt | (eq & q[0]);
         3'd2:    up = sgn & inexact;
         3'd3:    up = !sgn & inexact;
         3'd4:    up = gt | eq;
         default: up = 0;
      endcase
      n = q + longint'(up);
      v = sgn ? -longint'(n) : longint'(n);
      if (uns) in_rng = (v >= 0) && (v <= 64'sd4294967295);
      else     in_rng = (v >= -64'sd2147483648) && (v <= 64'sd2147483647);
      if (!in_rng) return sat(sgn, uns);
      o.res = v[31:0];
      o.nx = inexact;
      return o;
   endfunction

   // Scoreboard / checker: every negedge, compare outputs to the queue head.
   always @(negedge clk_i) begin
      ent_t en;
      res_t m;
      if (!reset_i) begin
         tests++;
         if (out_valid_o !== 1'b0 || result_o !== 32'h0 || flag_nv_o !== 1'b0 || flag_nx_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got valid=%b res=%h nv=%b nx=%b, expected all zero",
                     out_valid_o, result_o, flag_nv_o, flag_nx_o);
         end
         exp_q.delete();
         chk_empty_next = 0;
      end else begin
         if (rdy_chk_en) begin
            tests++;
            if (in_ready_o !== rdy_chk_val) begin
               fails++;
               $display("FAIL in_ready: got %b, expected %b", in_ready_o, rdy_chk_val);
            end
         end
         if (chk_empty_next) begin
            tests++;
            if (out_valid_o !== 1'b0) begin
               fails++;
               $display("FAIL kill_next_edge: out_valid got %b, expected 0", out_valid_o);
            end
            chk_empty_next = 0;
         end
         if (out_valid_o === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL spurious_result: got res=%h with no operand pending, expected none", result_o);
            end else begin
               en = exp_q[0];
               if ({result_o, flag_nv_o, flag_nx_o} !== en.exp) begin
                  fails++;
                  $display("FAIL result op=%h uns=%b rm=%0d: got res=%h nv=%b nx=%b, expected res=%h nv=%b nx=%b",
                           en.op, en.uns, en.rm, result_o, flag_nv_o, flag_nx_o, en.exp.res, en.exp.nv, en.exp.nx);
               end
               if (out_ready_i) begin
                  if (en.has_lit) begin
                     tests++;
                     if ({result_o, flag_nv_o, flag_nx_o} !== en.lit) begin
                        fails++;
                        $display("FAIL literal op=%h uns=%b rm=%0d: got res=%h nv=%b nx=%b, expected res=%h nv=%b nx=%b",
                                 en.op, en.uns, en.rm, result_o, flag_nv_o, flag_nx_o, en.lit.res, en.lit.nv, en.lit.nx);
                     end
                  end
                  void'(exp_q.pop_front());
               end
            end
         end
         if (flush_i) begin
            exp_q.delete();
            chk_empty_next = 1;
         end else if (in_valid_i && in_ready_o) begin
            m = model(op_a_i, is_unsigned_i, rounding_mode_i);
            en.op = op_a_i; en.uns = is_unsigned_i; en.rm = rounding_mode_i;
            en.exp = m; en.has_lit = lit_en; en.lit = lit_val;
            if (lit_en) begin
               tests++;
               if (m !== lit_val) begin
                  fails++;
                  $display("FAIL model_pin op=%h: got res=%h nv=%b nx=%b, expected res=%h nv=%b nx=%b",
                           op_a_i, m.res, m.nv, m.nx, lit_val.res, lit_val.nv, lit_val.nx);
               end
            end
            exp_q.push_back(en);
         end
      end
   end

   task automatic tick();
      @(posedge clk_i); #1;
      if (rand_rdy) out_ready_i = ($urandom_range(0, 99) < 70);
   endtask

   task automatic send(input logic [31:0] op, input logic uns, input logic [2:0] rm);
      bit acc;
      int n;
      n = 0;
      in_valid_i = 1'b1; op_a_i = op; is_unsigned_i = uns; rounding_mode_i = rm;
      forever begin
         @(negedge clk_i);
         acc = in_ready_o;
         tick();
         if (acc) break;
         n++;
         if (n > 200) begin
            $display("FAIL send_timeout: in_ready stayed low for %0d cycles, expected accept", n);
            $fatal(1, "handshake stalled");
         end
      end
      in_valid_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      rand_rdy = 0;
      out_ready_i = 1'b1;
      while (exp_q.size() != 0) begin
         tick();
         n++;
         if (n > 100) begin
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
            $fatal(1, "results never emerged");
         end
      end
      repeat (3) tick();
   endtask

   task automatic lit_case(input logic [31:0] op, input logic uns, input logic [2:0] rm,
                           input logic [31:0] res, input logic nv, input logic nx);
      lit_en = 1; lit_val = {res, nv, nx};
      send(op, uns, rm);
      lit_en = 0;
      drain();
   endtask

   function automatic logic [31:0] rand_op();
      int r;
      logic s;
      logic [7:0] ex;
      logic [22:0] fr, msk;
      r = $urandom_range(0, 99);
      s = 1'($urandom_range(0, 1));
      fr = 23'($urandom());
      if ($urandom_range(0, 1) == 1) begin
         msk = (23'd1 << $urandom_range(0, 22)) - 23'd1;
         fr = fr & ~msk;
      end
      if (r < 4) begin
         ex = 8'hFF;
         if (r < 2) fr = '0;
      end else if (r < 8) ex = 8'h00;
      else if (r < 25) ex = 8'(127 + $urandom_range(29, 33));
      else if (r < 30) ex = 8'($urandom());
      else ex = 8'($urandom_range(112, 160));
      return {s, ex, fr};
   endfunction

   initial begin
      reset_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; op_a_i = '0;
      is_unsigned_i = 1'b0; rounding_mode_i = '0; out_ready_i = 1'b1;
      #1 reset_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 reset_i = 1'b1;
      rdy_chk_en = 1; rdy_chk_val = 1;
      tick();
      rdy_chk_en = 0;

      // Hand-computed expectations
      lit_case(32'h40200000, 0, 3'd0, 32'd2, 0, 1);
      lit_case(32'h40200000, 0, 3'd4, 32'd3, 0, 1);
      lit_case(32'h40200000, 0, 3'd3, 32'd3, 0, 1);
      lit_case(32'h40200000, 0, 3'd1, 32'd2, 0, 1);
      lit_case(32'h40200000, 0, 3'd5, 32'd2, 0, 1);
      lit_case(32'hBFC00000, 0, 3'd2, 32'hFFFFFFFE, 0, 1);
      lit_case(32'hBF000000, 1, 3'd1, 32'h0, 0, 1);
      lit_case(32'hBF000000, 1, 3'd2, 32'h0, 1, 0);
      lit_case(32'h4F000000, 0, 3'd0, 32'h7FFFFFFF, 1, 0);
      lit_case(32'hCF000000, 0, 3'd0, 32'h80000000, 0, 0);
      lit_case(32'hCF000001, 0, 3'd1, 32'h80000000, 1, 0);
      lit_case(32'h7FC00000, 0, 3'd0, 32'h7FFFFFFF, 1, 0);
      lit_case(32'h7FC00000, 1, 3'd0, 32'hFFFFFFFF, 1, 0);
      lit_case(32'hFF800000, 0, 3'd0, 32'h80000000, 1, 0);
      lit_case(32'h3F400000, 0, 3'd0, 32'd1, 0, 1);
      lit_case(32'h80000000, 0, 3'd0, 32'd0, 0, 0);
      lit_case(32'h4F7FFFFF, 1, 3'd0, 32'hFFFFFF00, 0, 0);
      lit_case(32'h4F800000, 1, 3'd0, 32'hFFFFFFFF, 1, 0);

      // Backpressure: two accepts then in_ready drops; results held and ordered
      out_ready_i = 1'b0;
      in_valid_i = 1'b1; is_unsigned_i = 1'b0; rounding_mode_i = 3'd0;
      op_a_i = 32'h40200000; rdy_chk_en = 1; rdy_chk_val = 1;
      tick();
      op_a_i = 32'hC0600000;
      tick();
      op_a_i = 32'h3F400000; rdy_chk_val = 0;
      repeat (4) tick();
      rdy_chk_en = 0;
      out_ready_i = 1'b1;
      send(32'h3F400000, 0, 3'd0);
      send(32'h4B000001, 0, 3'd0);
      drain();

      // Flush with two operands in flight
      out_ready_i = 1'b0;
      send(32'h41200000, 0, 3'd0);
      send(32'h41300000, 0, 3'd0);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      repeat (2) tick();
      // Flush wins over a simultaneous accept
      out_ready_i = 1'b1;
      in_valid_i = 1'b1; op_a_i = 32'h42000000;
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0; in_valid_i = 1'b0;
      repeat (3) tick();
      send(32'h40400000, 0, 3'd1);
      drain();

      // Reset with two operands in flight
      out_ready_i = 1'b0;
      send(32'h41200000, 1, 3'd0);
      send(32'h41300000, 1, 3'd0);
      reset_i = 1'b0;
      repeat (2) tick();
      reset_i = 1'b1;
      rdy_chk_en = 1; rdy_chk_val = 1;
      tick();
      rdy_chk_en = 0;
      out_ready_i = 1'b1;
      send(32'hC1200000, 0, 3'd2);
      drain();

      // Randomized traffic with random backpressure and rare flushes
      rand_rdy = 1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) tick();
         if ($urandom_range(0, 199) == 0) begin
            flush_i = 1'b1;
            tick();
            flush_i = 1'b0;
         end
         send(rand_op(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
